// File: rtl/filter_test_sequencer_pkg.sv
// Shared types and default sizes for the filter test sequencer.
// State encoding is fixed so captured debug dumps stay decodable.
package filter_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 4;
    localparam int DEF_DIV_W   = 4;

endpackage

// File: rtl/filter_test_sequencer_strobe_divider.sv
// Clock-enable divider: strobe on the first enabled clock, then
// every div+1 clocks. Counter is held at zero while disabled.
module strobe_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             samp_en
);

    logic [DIV_W-1:0] cnt;

    assign samp_en = en && (cnt == '0);

    // Free-running modulo div+1 counter while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/filter_test_sequencer.sv
// Stimulus/capture sequencer for bench-testing a filter core.
// Captures run LATENCY strobes behind the stimulus address.
module filter_test_sequencer
    import filter_test_sequencer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int DIV_W   = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] filt_out,
    output logic [ADDR_W-1:0] stim_addr,
    output logic              stim_zero,
    output logic              samp_en,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [DATA_W-1:0] cap_data,
    output logic              cap_wren,
    output logic              busy,
    output logic              done,
    output logic              trigOut
);

    localparam int WARM_W = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [WARM_W-1:0] WARM_END = WARM_W'(LATENCY);

    state_t            state;
    logic              cont_q;
    logic              stop_q;
    logic [DIV_W-1:0]  div_q;
    logic [WARM_W-1:0] warm;
    logic              run_en;
    logic              warm_done;

    assign run_en    = (state == ST_RUN) || (state == ST_FLUSH);
    assign warm_done = (warm == WARM_END);
    assign busy      = run_en;
    assign done      = (state == ST_DONE);
    assign stim_zero = (state == ST_FLUSH);
    assign cap_wren  = samp_en && warm_done;
    assign cap_data  = cap_wren ? filt_out : '0;
    assign trigOut   = samp_en && (state == ST_RUN) && (stim_addr == '0);

    strobe_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst),
        .en     (run_en),
        .div    (div_q),
        .samp_en(samp_en)
    );

    // Frame sequencing, address counters and warmup tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cont_q    <= 1'b0;
            stop_q    <= 1'b0;
            div_q     <= '0;
            warm      <= '0;
            stim_addr <= '0;
            cap_addr  <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    stop_q <= 1'b0;
                    if (start && !stop) begin
                        state     <= ST_RUN;
                        cont_q    <= continuous;
                        div_q     <= div;
                        warm      <= '0;
                        stim_addr <= '0;
                        cap_addr  <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (samp_en) begin
                        if (!warm_done) begin
                            warm <= warm + 1'b1;
                        end
                        if (cap_wren) begin
                            cap_addr <= (cap_addr == LAST) ?
                                        '0 : cap_addr + 1'b1;
                        end
                        if (stim_addr == LAST) begin
                            stim_addr <= '0;
                            if (!cont_q || stop_q || stop) begin
                                state <= ST_FLUSH;
                            end
                        end else begin
                            stim_addr <= stim_addr + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Last write holds cap_addr so it reads DEPTH-1 in DONE
                    if (cap_wren) begin
                        if (cap_addr == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            cap_addr <= cap_addr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Scoreboard bench for filter_test_sequencer with a delay-line
// filter model: capture at address n must hold 0xA500 + n.
module tb_filter_test_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
    localparam int LAT    = 3;
    localparam int DIV_W  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [DATA_W-1:0] filt_out;
    logic [ADDR_W-1:0] stim_addr;
    logic              stim_zero;
    logic              samp_en;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_wren;
    logic              busy;
    logic              done;
    logic              trigOut;

    logic [ADDR_W-1:0] pipe [LAT];

    exp_t q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_zero = 0;
    int n_trig = 0;
    int n_busy = 0;
    int per_err = 0;
    int last_cyc = -1;
    int period = 1;
    int b_strobe, b_zero, b_trig, b_busy, b_per;

    filter_test_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LAT),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .continuous(continuous),
        .div       (div),
        .filt_out  (filt_out),
        .stim_addr (stim_addr),
        .stim_zero (stim_zero),
        .samp_en   (samp_en),
        .cap_addr  (cap_addr),
        .cap_data  (cap_data),
        .cap_wren  (cap_wren),
        .busy      (busy),
        .done      (done),
        .trigOut   (trigOut)
    );

    always #5 clk = ~clk;

    // Filter model: LAT-stage delay line advanced by each strobe
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (samp_en) begin
            pipe[0] <= stim_zero ? '0 : stim_addr;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign filt_out = 16'hA500 + {12'b0, pipe[LAT-1]};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) n_busy++;
            if (trigOut) n_trig++;
            if (samp_en) begin
                n_strobe++;
                if (stim_zero) n_zero++;
                if (last_cyc >= 0 && (cyc - last_cyc) != period) per_err++;
                last_cyc = cyc;
            end
            if (cap_wren) begin
                check("wren_on_strobe", samp_en, 1);
                if (q.size() == 0) begin
                    check("unexpected_write", cap_addr, 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    check("cap_addr", cap_addr, e.addr);
                    check("cap_data", cap_data, e.data);
                end
            end
        end
    endtask

    task automatic snap();
        b_strobe = n_strobe;
        b_zero   = n_zero;
        b_trig   = n_trig;
        b_busy   = n_busy;
        b_per    = per_err;
    endtask

    task automatic run_frame(bit c, int dv, int nexp);
        exp_t e;
        for (int i = 0; i < nexp; i++) begin
            e.addr = ADDR_W'(i % DEPTH);
            e.data = 16'hA500 + 16'(i % DEPTH);
            q.push_back(e);
        end
        snap();
        period = dv + 1;
        last_cyc = -1;
        continuous = c;
        div = DIV_W'(dv);
        start = 1'b1;
        tick();
        start = 1'b0;
        continuous = 1'b0;
        div = '0;
    endtask

    task automatic wait_done(string name);
        for (int i = 0; i < 2000 && !done; i++) tick();
        check(name, done, 1);
    endtask

    task automatic check_zero(string name);
        check(name, {stim_addr, stim_zero, samp_en, cap_addr, cap_data,
                     cap_wren, busy, done, trigOut}, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #12;
        check_zero("reset_outputs");
        tick();
        rst = 1'b1;
        tick();

        // single shot, strobe every clock
        run_frame(0, 0, 8);
        wait_done("ss_done");
        check("ss_strobes", n_strobe - b_strobe, 11);
        check("ss_zero", n_zero - b_zero, 3);
        check("ss_trig", n_trig - b_trig, 1);
        check("ss_busy", n_busy - b_busy, 11);
        check("ss_left", q.size(), 0);
        check("ss_capaddr", cap_addr, 7);
        check("ss_busy_low", busy, 0);

        // single shot, div=3
        run_frame(0, 3, 8);
        wait_done("div3_done");
        check("div3_strobes", n_strobe - b_strobe, 11);
        check("div3_busy", n_busy - b_busy, 41);
        check("div3_period", per_err - b_per, 0);
        check("div3_left", q.size(), 0);

        // continuous, stop during second frame
        run_frame(1, 0, 16);
        for (int i = 0; i < 200 && (n_trig - b_trig) < 2; i++) tick();
        check("cont_trig_wait", (n_trig - b_trig) >= 2, 1);
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("cont_done");
        check("cont_trig", n_trig - b_trig, 2);
        check("cont_strobes", n_strobe - b_strobe, 19);
        check("cont_zero", n_zero - b_zero, 3);
        check("cont_left", q.size(), 0);
        check("cont_capaddr", cap_addr, 7);

        // start during RUN is ignored
        run_frame(0, 1, 8);
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        continuous = 1'b1;
        div = 4'd0;
        tick();
        start = 1'b0;
        continuous = 1'b0;
        wait_done("rerun_done");
        check("rerun_strobes", n_strobe - b_strobe, 11);
        check("rerun_busy", n_busy - b_busy, 21);
        check("rerun_period", per_err - b_per, 0);
        check("rerun_left", q.size(), 0);

        // start+stop together from DONE: stay in DONE
        snap();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();
        check("ss_from_done", {busy, done}, 2'b01);
        check("ss_from_done_strb", n_strobe - b_strobe, 0);

        // reset in the middle of a frame
        run_frame(0, 0, 8);
        for (int i = 0; i < 50 && stim_addr != 4'd5; i++) tick();
        check("mid_addr5", stim_addr, 5);
        rst = 1'b0;
        #1;
        check_zero("mid_reset_outputs");
        check("mid_popped", q.size(), 6);
        q.delete();
        snap();
        tick();
        tick();
        check("mid_hold_strb", n_strobe - b_strobe, 0);
        rst = 1'b1;
        tick();

        // start+stop together from IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();
        check("ss_from_idle", {busy, done}, 2'b00);

        // clean frame after reset
        run_frame(0, 0, 8);
        wait_done("post_done");
        check("post_strobes", n_strobe - b_strobe, 11);
        check("post_left", q.size(), 0);
        check("post_capaddr", cap_addr, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
